// File: rtl/sa_pkg.sv
// Shared types and widths for the systolic-array skew feeder.
package sa_pkg;
    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam int SA_WIDTH = 32;
    localparam int KLEN_W   = 16;
endpackage

// File: rtl/sa_skew_lane.sv
// One skew lane: DEPTH-stage shift register with enable and zero-fill.
module sa_skew_lane #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             shift_en,
    input  logic             zero_fill,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sr <= '0;
        end else if (shift_en) begin
            sr[0] <= zero_fill ? '0 : d;
            for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
    end

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/sa_skew_feeder.sv
// Skews A/B operand vectors into a systolic array and drains it with zeros.
// Optional SA_FEED_CLR_EN adds a one-cycle accumulator-clear pulse (clr).
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int HPE   = 4,
    parameter int VPE   = 4,
    parameter int WIDTH = SA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [KLEN_W-1:0]     k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH*HPE-1:0]  a_in,
    input  logic [WIDTH*VPE-1:0]  b_in,
    output logic [WIDTH*HPE-1:0]  a_out,
    output logic [WIDTH*VPE-1:0]  b_out,
    output logic                  out_valid,
    output logic                  busy,
`ifdef SA_FEED_CLR_EN
    output logic                  clr,
`endif
    output logic                  done
);
    localparam int FL_LEN = HPE + VPE - 1;
    localparam int FL_W   = $clog2(FL_LEN + 1);

    state_t            state;
    logic [KLEN_W-1:0] beat_cnt;
    logic [FL_W-1:0]   flush_cnt;
    logic              accept;
    logic              flushing;
    logic              shift_en;

    assign accept   = (state == S_FEED) && in_valid;
    assign flushing = (state == S_FLUSH);
    assign shift_en = accept || flushing;

    assign in_ready = (state == S_FEED);
    assign busy     = (state == S_FEED) || (state == S_FLUSH);
    assign done     = (state == S_DONE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= shift_en;
            case (state)
                S_IDLE: if (start) begin
                    if (k_len != '0) begin
                        state    <= S_FEED;
                        beat_cnt <= k_len;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_FEED: if (in_valid) begin
                    beat_cnt <= beat_cnt - 1'b1;
                    if (beat_cnt == KLEN_W'(1)) begin
                        state     <= S_FLUSH;
                        flush_cnt <= FL_W'(FL_LEN);
                    end
                end
                // drain long enough for the last beat to cross the whole array
                S_FLUSH: begin
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt == FL_W'(1)) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SA_FEED_CLR_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) clr <= 1'b0;
        else      clr <= (state == S_IDLE) && start;
    end
`endif

    for (genvar i = 0; i < HPE; i++) begin : g_a
        sa_skew_lane #(.DEPTH(i + 1), .WIDTH(WIDTH)) u_lane (
            .CLK       (CLK),
            .RST       (RST),
            .shift_en  (shift_en),
            .zero_fill (flushing),
            .d         (a_in[i*WIDTH +: WIDTH]),
            .q         (a_out[i*WIDTH +: WIDTH])
        );
    end

    for (genvar j = 0; j < VPE; j++) begin : g_b
        sa_skew_lane #(.DEPTH(j + 1), .WIDTH(WIDTH)) u_lane (
            .CLK       (CLK),
            .RST       (RST),
            .shift_en  (shift_en),
            .zero_fill (flushing),
            .d         (b_in[j*WIDTH +: WIDTH]),
            .q         (b_out[j*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder (HPE=VPE=4, WIDTH=32).
module tb_sa_skew_feeder;
    localparam int HPE = 4;
    localparam int VPE = 4;
    localparam int W   = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic [15:0]       k_len;
    logic              in_valid;
    logic              in_ready;
    logic [W*HPE-1:0]  a_in;
    logic [W*VPE-1:0]  b_in;
    logic [W*HPE-1:0]  a_out;
    logic [W*VPE-1:0]  b_out;
    logic              out_valid;
    logic              busy;
    logic              done;
`ifdef SA_FEED_CLR_EN
    logic              clr;
`endif

    int checks   = 0;
    int failures = 0;

    sa_skew_feeder #(.HPE(HPE), .VPE(VPE), .WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .out_valid (out_valid),
        .busy      (busy),
`ifdef SA_FEED_CLR_EN
        .clr       (clr),
`endif
        .done      (done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alane(input int i);
        return a_out[i*W +: W];
    endfunction

    function automatic logic [31:0] blane(input int j);
        return b_out[j*W +: W];
    endfunction

    // A lane i of beat n = (i+1)+16n; B lane j = 0x100+(j+1)+16n
    task automatic set_beat(input int n);
        for (int i = 0; i < HPE; i++) a_in[i*W +: W] = 32'(i + 1 + 16*n);
        for (int j = 0; j < VPE; j++) b_in[j*W +: W] = 32'(32'h100 + j + 1 + 16*n);
    endtask

    // after the last accept: 7 flush shifts, done in the 7th cycle
    task automatic expect_done_after_flush(input string tag);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk({tag, "_done"}, {31'd0, done}, {31'd0, k == 7});
            chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
        end
        tick();
        chk({tag, "_done_end"}, {31'd0, done}, 32'd0);
        chk({tag, "_ov_end"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        RST = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_in = '0; b_in = '0;
        #1;
        chk("rst_a", a_out[31:0], 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        tick();
        RST = 1'b1;
        tick();

        // basic frame, k_len=3, in_valid held high
        start = 1'b1; k_len = 16'd3; in_valid = 1'b1; set_beat(0);
        tick();
        start = 1'b0; k_len = 16'd0;
        chk("f1_busy", {31'd0, busy}, 32'd1);
        chk("f1_ready", {31'd0, in_ready}, 32'd1);
        for (int n = 0; n < 3; n++) begin
            set_beat(n);
            tick();
            chk("f1_a0", alane(0), 32'(1 + 16*n));
            chk("f1_b0", blane(0), 32'(32'h101 + 16*n));
            chk("f1_ov", {31'd0, out_valid}, 32'd1);
            chk("f1_a3_early", alane(3), 32'd0);
        end
        chk("f1_ready_flush", {31'd0, in_ready}, 32'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("f1_done", {31'd0, done}, {31'd0, k == 7});
            chk("f1_a0_zero", alane(0), 32'd0);
            if (k <= 3) begin
                chk("f1_a3", alane(3), 32'(4 + 16*(k-1)));
                chk("f1_b3", blane(3), 32'(32'h104 + 16*(k-1)));
            end else begin
                chk("f1_a3_zero", alane(3), 32'd0);
            end
            chk("f1_busy_fl", {31'd0, busy}, {31'd0, k != 7});
        end
        tick();
        chk("f1_done_end", {31'd0, done}, 32'd0);
        chk("f1_ov_end", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;

        // stall: k_len=2, 3-cycle gap between beats
        start = 1'b1; k_len = 16'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; set_beat(0);
        tick();
        chk("st_a0_b0", alane(0), 32'd1);
        chk("st_ov_b0", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0; set_beat(1);
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("st_ov_gap", {31'd0, out_valid}, 32'd0);
            chk("st_a0_hold", alane(0), 32'd1);
            chk("st_a1_hold", alane(1), 32'd0);
            chk("st_ready_gap", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b1;
        tick();
        chk("st_a0_b1", alane(0), 32'd17);
        chk("st_a1_b0", alane(1), 32'd2);
        chk("st_ov_b1", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        chk("st_ready_flush", {31'd0, in_ready}, 32'd0);
        expect_done_after_flush("st");

        // zero-length frame
        start = 1'b1; k_len = 16'd0; in_valid = 1'b1;
        tick();
        start = 1'b0;
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_ready", {31'd0, in_ready}, 32'd0);
        chk("z_ov", {31'd0, out_valid}, 32'd0);
        chk("z_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("z_done_end", {31'd0, done}, 32'd0);
        chk("z_ov_end", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;

        // reset during flush cycle 2
        start = 1'b1; k_len = 16'd2;
        tick();
        start = 1'b0; in_valid = 1'b1; set_beat(0);
        tick();
        set_beat(1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("rf_a1_pre", alane(1), 32'd18);
        RST = 1'b0;
        #1;
        chk("rf_a1", alane(1), 32'd0);
        chk("rf_a2", alane(2), 32'd0);
        chk("rf_b1", blane(1), 32'd0);
        chk("rf_ov", {31'd0, out_valid}, 32'd0);
        chk("rf_busy", {31'd0, busy}, 32'd0);
        chk("rf_ready", {31'd0, in_ready}, 32'd0);
        chk("rf_done", {31'd0, done}, 32'd0);
        #2;
        RST = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rf_no_done", {31'd0, done}, 32'd0);
        end
        start = 1'b1; k_len = 16'd1;
        tick();
        start = 1'b0; in_valid = 1'b1; set_beat(2);
        tick();
        in_valid = 1'b0;
        chk("rf_new_a0", alane(0), 32'd33);
        expect_done_after_flush("rf_new");

        // start pulsed during FEED must not reload the beat count
        start = 1'b1; k_len = 16'd3;
        tick();
        start = 1'b1; k_len = 16'd9; in_valid = 1'b1; set_beat(0);
        tick();
        start = 1'b0; set_beat(1);
        tick();
        set_beat(2);
        tick();
        in_valid = 1'b0;
        chk("sb_ready", {31'd0, in_ready}, 32'd0);
        chk("sb_busy", {31'd0, busy}, 32'd1);
        chk("sb_a0", alane(0), 32'd33);
        expect_done_after_flush("sb");

`ifdef SA_FEED_CLR_EN
        start = 1'b1; k_len = 16'd5;
        #0;
        chk("clr_idle", {31'd0, clr}, 32'd0);
        tick();
        start = 1'b0;
        chk("clr_pulse", {31'd0, clr}, 32'd1);
        chk("clr_ov", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        tick();
        chk("clr_end", {31'd0, clr}, 32'd0);
        in_valid = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
